// File: rtl/flagram_param.sv
// flagram_param -- single-port RAM that stores a 4-bit flag word next to each
// data word, with a whole-array clear sweep.
//
// Flag word, computed from the write data when it is written:
//   [0] zero      (data == 0)
//   [1] parity    (XOR of all data bits)
//   [2] sign      (data MSB)
//   [3] all-ones  (every data bit set)
//
// Optional feature macro: FLAGRAM_STICKY_EN
//   When defined, o_w_sticky presents the OR of the flag words of every
//   accepted write since reset or since the last completed clear sweep.
//   When undefined, the port and its register do not exist.
//
// Ports:
//   i_w_clk        clock, all state changes on the rising edge
//   i_w_reset      synchronous active-high reset
//   i_w_address    read/write address
//   i_w_data       write data
//   i_w_we         write enable
//   i_w_oe         read data request (wins over i_w_flags_out)
//   i_w_flags_out  read flag-word request (zero-extended result)
//   i_w_clear      start a clear sweep of the whole array
//   o_w_out        read result, 0 when o_w_valid is low
//   o_w_valid      o_w_out holds a read result this cycle (1-cycle latency)
//   o_w_busy       clear sweep in progress; all requests ignored
//   o_w_sticky     accumulated flags (FLAGRAM_STICKY_EN only)
module flagram_param #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  i_w_clk,
    input  logic                  i_w_reset,
    input  logic [ADDR_WIDTH-1:0] i_w_address,
    input  logic [DATA_WIDTH-1:0] i_w_data,
    input  logic                  i_w_we,
    input  logic                  i_w_oe,
    input  logic                  i_w_flags_out,
    input  logic                  i_w_clear,
    output logic [DATA_WIDTH-1:0] o_w_out,
    output logic                  o_w_valid,
    output logic                  o_w_busy
`ifdef FLAGRAM_STICKY_EN
    ,
    output logic [3:0]            o_w_sticky
`endif
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDR_WIDTH-1:0]   sweep_cnt;
    logic                    sweep_last;

    logic [DATA_WIDTH-1:0]   mem_data  [DEPTH];
    logic [3:0]              mem_flags [DEPTH];

    logic                    wr_en;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic [3:0]              wr_flags;
    logic                    rd_en;

    logic [DATA_WIDTH-1:0]   out_p1;
    logic                    vld_p1;

    function automatic logic [3:0] calc_flags(input logic [DATA_WIDTH-1:0] d);
        calc_flags = {&d, d[DATA_WIDTH-1], ^d, ~|d};
    endfunction

    assign sweep_last = (sweep_cnt == ADDR_WIDTH'(DEPTH - 1));

    // State register and sweep address counter
    always_ff @(posedge i_w_clk) begin
        if (i_w_reset) begin
            state     <= IDLE;
            sweep_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == CLEAR) begin
                // Return to 0 at the end of the sweep instead of wrapping.
                sweep_cnt <= sweep_last ? '0 : sweep_cnt + 1'b1;
            end
        end
    end

    // Next state and array port selection
    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        wr_addr   = i_w_address;
        wr_data   = i_w_data;
        wr_flags  = calc_flags(i_w_data);
        rd_en     = 1'b0;
        o_w_busy  = 1'b0;
        case (state)
            IDLE: begin
                // A clear request drops any write/read issued with it.
                if (i_w_clear) begin
                    state_nxt = CLEAR;
                end else begin
                    wr_en = i_w_we;
                    rd_en = i_w_oe | i_w_flags_out;
                end
            end
            CLEAR: begin
                o_w_busy = 1'b1;
                wr_en    = 1'b1;
                wr_addr  = sweep_cnt;
                wr_data  = '0;
                wr_flags = 4'b0001;
                if (sweep_last) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        // Reset overrides everything on its edge, including the sweep write,
        // so an aborted sweep leaves only the entries already swept cleared.
        if (i_w_reset) begin
            wr_en = 1'b0;
            rd_en = 1'b0;
        end
    end

    // Array write (contents are not reset)
    always_ff @(posedge i_w_clk) begin
        if (wr_en) begin
            mem_data[wr_addr]  <= wr_data;
            mem_flags[wr_addr] <= wr_flags;
        end
    end

    // Read stage p1: registered read, sees pre-write contents on a same-edge write
    always_ff @(posedge i_w_clk) begin
        if (i_w_reset) begin
            out_p1 <= '0;
            vld_p1 <= 1'b0;
        end else if (rd_en) begin
            vld_p1 <= 1'b1;
            out_p1 <= i_w_oe ? mem_data[i_w_address]
                             : DATA_WIDTH'(mem_flags[i_w_address]);
        end else begin
            out_p1 <= '0;
            vld_p1 <= 1'b0;
        end
    end

    assign o_w_out   = out_p1;
    assign o_w_valid = vld_p1;

`ifdef FLAGRAM_STICKY_EN
    logic [3:0] sticky_q;

    always_ff @(posedge i_w_clk) begin
        if (i_w_reset) begin
            sticky_q <= 4'b0000;
        end else if (state == CLEAR && sweep_last) begin
            sticky_q <= 4'b0000;
        end else if (state == IDLE && wr_en) begin
            sticky_q <= sticky_q | wr_flags;
        end
    end

    assign o_w_sticky = sticky_q;
`endif

endmodule

// File: tb/tb_flagram_param.sv
// tb_flagram_param -- directed scoreboard bench for flagram_param
// (DATA_WIDTH=8, ADDR_WIDTH=4). Stimulus pushes hand-computed read results
// into a queue; a negedge monitor pops and compares whenever o_w_valid is high.
module tb_flagram_param;

    logic       clk;
    logic       rst;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic       we;
    logic       oe;
    logic       fl;
    logic       clr;
    logic [7:0] out;
    logic       vld;
    logic       busy;
`ifdef FLAGRAM_STICKY_EN
    logic [3:0] sticky;
`endif

    int         n_chk  = 0;
    int         n_fail = 0;
    logic [7:0] exp_q[$];
    logic       mon_en = 1'b0;

    flagram_param #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(4)
    ) dut (
        .i_w_clk       (clk),
        .i_w_reset     (rst),
        .i_w_address   (addr),
        .i_w_data      (wdata),
        .i_w_we        (we),
        .i_w_oe        (oe),
        .i_w_flags_out (fl),
        .i_w_clear     (clr),
        .o_w_out       (out),
        .o_w_valid     (vld),
        .o_w_busy      (busy)
`ifdef FLAGRAM_STICKY_EN
        ,
        .o_w_sticky    (sticky)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: compares every presented read result against the scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            if (vld === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_valid: actual out=%0h valid=1 required valid=0 (t=%0t)",
                             out, $time);
                end else begin
                    check("read_result", {24'd0, out}, {24'd0, exp_q.pop_front()});
                end
            end else begin
                check("out_zero_when_invalid", {24'd0, out}, 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we  = 1'b0;
        oe  = 1'b0;
        fl  = 1'b0;
        clr = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        tick();
        idle();
    endtask

    task automatic rd(input logic [3:0] a, input logic o, input logic f, input logic [7:0] e);
        addr = a;
        oe   = o;
        fl   = f;
        exp_q.push_back(e);
        tick();
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst   = 1'b1;
        addr  = '0;
        wdata = '0;
        idle();
        oe    = 1'b1;                       // reset must override a read request
        repeat (2) tick();
        check("reset_out", {24'd0, out}, 32'd0);
        check("reset_valid", {31'd0, vld}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
`ifdef FLAGRAM_STICKY_EN
        check("reset_sticky", {28'd0, sticky}, 32'd0);
`endif
        rst    = 1'b0;
        oe     = 1'b0;
        mon_en = 1'b1;

        // Data and flag reads
        wr(4'd3, 8'h80);
        wr(4'd15, 8'hFF);
`ifdef FLAGRAM_STICKY_EN
        check("sticky_after_80_ff", {28'd0, sticky}, 32'hE);
`endif
        rd(4'd3, 1'b1, 1'b0, 8'h80);
        rd(4'd3, 1'b0, 1'b1, 8'h06);
        rd(4'd15, 1'b0, 1'b1, 8'h0C);
        rd(4'd15, 1'b1, 1'b1, 8'hFF);       // oe wins over flags_out
        wr(4'd0, 8'h00);
        rd(4'd0, 1'b0, 1'b1, 8'h01);
        tick();                             // idle cycle: out must be 0

        // Same-edge write and read returns pre-write contents
        wr(4'd5, 8'h80);
        addr  = 4'd5;
        wdata = 8'h07;
        we    = 1'b1;
        oe    = 1'b1;
        exp_q.push_back(8'h80);
        tick();
        idle();
        rd(4'd5, 1'b1, 1'b0, 8'h07);
        rd(4'd5, 1'b0, 1'b1, 8'h02);

        // Clear sweep; the write/read issued with the clear are dropped
        addr  = 4'd7;
        wdata = 8'h33;
        we    = 1'b1;
        oe    = 1'b1;
        clr   = 1'b1;
        tick();
        idle();
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            addr  = 4'(n);
            wdata = 8'hAA;
            we    = 1'b1;
            oe    = 1'b1;
            fl    = 1'b1;
            clr   = 1'b1;
            n++;
            tick();
        end
        idle();
        check("busy_cycles", n, 32'd16);
`ifdef FLAGRAM_STICKY_EN
        check("sticky_after_clear", {28'd0, sticky}, 32'd0);
`endif
        for (int i = 0; i < 16; i++) begin
            rd(4'(i), 1'b1, 1'b0, 8'h00);
            rd(4'(i), 1'b0, 1'b1, 8'h01);
        end

        // Reset five cycles into a sweep aborts it
        for (int i = 0; i < 6; i++) wr(4'(i), 8'h11);
        wr(4'd10, 8'h5A);
        clr = 1'b1;
        tick();
        idle();
        repeat (5) tick();
        rst = 1'b1;
        oe  = 1'b1;
        tick();
        check("busy_after_reset", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        oe  = 1'b0;
        for (int i = 0; i < 5; i++) rd(4'(i), 1'b1, 1'b0, 8'h00);
        rd(4'd5, 1'b1, 1'b0, 8'h11);
        rd(4'd10, 1'b1, 1'b0, 8'h5A);
        rd(4'd10, 1'b0, 1'b1, 8'h00);       // 0x5A: even parity, no flags
        tick();
        check("no_pending_reads", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/flagram_param.md
FLAGRAM_PARAM -- requirements
Module: flagram_param

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: data word width; legal range 4..32.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4: address width; DEPTH = 2**ADDR_WIDTH entries.
REQ-003 SHALL have ports:
- i_w_clk  in  1  sole clock; all state changes on rising edge.
- i_w_reset  in  1  reset, synchronous, active-high.
- i_w_address  in  ADDR_WIDTH  read/write address.
- i_w_data  in  DATA_WIDTH  write data.
- i_w_we  in  1  write enable.
- i_w_oe  in  1  read-data request.
- i_w_flags_out  in  1  read-flags request.
- i_w_clear  in  1  start whole-array clear sweep.
- o_w_out  out  DATA_WIDTH  read result.
- o_w_valid  out  1  o_w_out holds a read result this cycle.
- o_w_busy  out  1  clear sweep in progress.
- o_w_sticky  out  4  accumulated flags; present only with FLAGRAM_STICKY_EN.

Function
REQ-004 SHALL store per entry a DATA_WIDTH data word plus a 4-bit flag word computed from write data at write time.
REQ-005 Flag bits SHALL be: [0] zero (data==0), [1] odd parity (XOR of all data bits), [2] sign (data MSB), [3] all-ones.
REQ-006 Write: i_w_we=1 in IDLE SHALL update data and flags at i_w_address on that edge.
REQ-007 Read: request sampled on edge N SHALL present result on o_w_out with o_w_valid=1 during cycle N+1 (1-cycle latency).
REQ-008 i_w_oe SHALL return stored data; i_w_flags_out alone SHALL return flag word zero-extended to DATA_WIDTH.
REQ-009 i_w_oe and i_w_flags_out both high SHALL return data (oe priority).
REQ-010 Read and write to the same address on the same edge SHALL return pre-write contents (read-first).
REQ-011 o_w_out SHALL be 0 whenever o_w_valid=0.
REQ-012 FSM states IDLE and CLEAR; IDLE->CLEAR on i_w_clear=1; CLEAR->IDLE after DEPTH sweep cycles.
REQ-013 CLEAR SHALL write data 0 and flags 4'b0001 to addresses 0..DEPTH-1, one per cycle, ascending; address counter SHALL not wrap past DEPTH-1.
REQ-014 o_w_busy SHALL be 1 exactly in the DEPTH cycles of CLEAR.
REQ-015 i_w_we, i_w_oe, i_w_flags_out, i_w_clear SHALL be ignored while busy (no write, o_w_valid=0).
REQ-016 i_w_clear together with i_w_we/i_w_oe in IDLE: clear SHALL take priority; the write and read SHALL be dropped.
REQ-017 Array contents SHALL be undefined until first written or cleared.

Reset
REQ-018 Reset SHALL force IDLE, sweep counter 0, o_w_out=0, o_w_valid=0, o_w_busy=0, o_w_sticky=0 on the next edge.
REQ-019 Reset SHALL not initialise the array; reset mid-clear SHALL abort the sweep, leaving already-swept entries cleared.
REQ-020 Reset SHALL override all other inputs on the same edge.

Configuration
REQ-021 Macro FLAGRAM_STICKY_EN defined: o_w_sticky SHALL be OR of flag words of every accepted write since reset or last clear completion; clear sweep completion SHALL zero it.
REQ-022 FLAGRAM_STICKY_EN undefined: o_w_sticky port and its register SHALL not exist; all other behaviour unchanged.

Verification (DATA_WIDTH=8, ADDR_WIDTH=4)
REQ-023 Write 0x80 @3, then oe @3 -> next cycle o_w_out=0x80, o_w_valid=1; flags_out @3 -> o_w_out=0x06.
REQ-024 Write 0xFF @15, flags_out @15 -> 0x0C; write 0x00 @0, flags_out @0 -> 0x01; idle cycle -> o_w_out=0x00, o_w_valid=0.
REQ-025 Same-edge write 0x07 and oe @5 holding 0x80 -> o_w_out=0x80; following oe -> 0x07; flags_out -> 0x02.
REQ-026 Pulse clear -> o_w_busy high 16 cycles; we/oe during busy ignored; then every address reads data 0x00, flags 0x01.
REQ-027 Reset asserted 5 cycles into clear -> busy=0 next cycle; addresses 0..4 read 0x00, address 10 retains prior value.
REQ-028 With FLAGRAM_STICKY_EN: writes 0x80 then 0xFF -> o_w_sticky=4'b1110; after clear completes -> 4'b0000.
